uart_arbiter: RTL and testbench
===============================

UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have ports req0_valid / req1_valid, input, 1 each: requester N has a byte to send.
REQ-004 SHALL have ports req0_data / req1_data, input, 8 each: byte from requester N; sampled only on acceptance.
REQ-005 SHALL have ports req0_ready / req1_ready, output, 1 each: one-cycle pulse; the byte from requester N is accepted in that cycle.
REQ-006 SHALL have port uart_start_tx, output, 1: UART transmit request, held high for the whole transfer.
REQ-007 SHALL have port uart_tx_value, output, 8: byte presented to the UART.
REQ-008 SHALL have port uart_tx_done, input, 1: UART transfer-complete level.
REQ-009 SHALL have ports uart_rx_available, input, 1, and uart_rx_value, input, 8: received byte from the UART and its valid level.
REQ-010 SHALL have port uart_rx_clear, output, 1: acknowledge to the UART receiver.
REQ-011 SHALL have ports rx_valid, output, 1, and rx_data, output, 8: holding register for the received byte.
REQ-012 SHALL have port rx_read, input, 1: consumer pops the holding register.
REQ-013 SHALL have port rx_overrun, output, 1: sticky flag set when a byte is lost.
REQ-014 SHALL have ports tx_busy, output, 1 (TX FSM not in T_IDLE), and tx_grant, output, 1 (index of the current or last granted requester).

Function
REQ-015 SHALL implement a TX FSM with states T_IDLE, T_SEND, T_RELEASE.
REQ-016 SHALL, in T_IDLE with at least one reqN_valid: pick a winner, latch its data into uart_tx_value, pulse its reqN_ready for exactly one cycle, set tx_grant, and enter T_SEND.
REQ-017 SHALL arbitrate round-robin: on simultaneous valid, grant the requester not granted last; a lone valid requester is always granted; after reset req0 has priority.
REQ-018 SHALL, in T_SEND, drive uart_start_tx=1 with uart_tx_value stable until uart_tx_done=1, then enter T_RELEASE with uart_start_tx=0 on the next cycle.
REQ-019 SHALL, in T_RELEASE, keep uart_start_tx=0 until uart_tx_done=0, then return to T_IDLE; no grant is issued in T_RELEASE.
REQ-020 SHALL leave reqN_valid unaffected while it waits; a requester holds valid and data until its ready pulse, and valid deasserted before grant is ignored.
REQ-021 SHALL implement an RX FSM with states R_WAIT and R_CLEAR, independent of the TX FSM.
REQ-022 SHALL, in R_WAIT with uart_rx_available=1: copy uart_rx_value into rx_data, set rx_valid=1, assert uart_rx_clear=1, and enter R_CLEAR.
REQ-023 SHALL, in R_CLEAR, hold uart_rx_clear=1 until uart_rx_available=0, then drive uart_rx_clear=0 and return to R_WAIT; exactly one capture occurs per received byte.
REQ-024 SHALL, on capture while rx_valid=1 with no rx_read in the same cycle, overwrite rx_data and set rx_overrun=1.
REQ-025 SHALL, on rx_read with rx_valid=1 and no simultaneous capture, clear rx_valid and rx_overrun next cycle; rx_read with rx_valid=0 has no effect.
REQ-026 SHALL, on simultaneous capture and rx_read, load the new byte, keep rx_valid=1, and leave rx_overrun unset by that event.
REQ-027 SHALL register all outputs, except that reqN_ready is asserted in the cycle of acceptance.

Reset
REQ-028 SHALL, on rst_n=0 at a clock edge, force T_IDLE and R_WAIT and set uart_start_tx, uart_tx_value, reqN_ready, uart_rx_clear, rx_valid, rx_data, rx_overrun, tx_busy, and tx_grant to 0, with priority to req0.
REQ-029 SHALL abandon any in-flight TX or RX transfer on reset mid-operation, with no ready pulse or capture for it after reset.

Verification
REQ-030 SHALL cover: req0_valid=1, data 0x55 -> req0_ready pulse, uart_tx_value=0x55 with start_tx high until tx_done, then T_IDLE after tx_done falls.
REQ-031 SHALL cover: req0 and req1 valid continuously with 0xA1/0xB2 -> UART sees 0xA1, 0xB2, 0xA1, 0xB2 alternately.
REQ-032 SHALL cover: rx_available with value 0x3C -> rx_data=0x3C, rx_valid=1, uart_rx_clear held until available drops, then cleared.
REQ-033 SHALL cover: two received bytes 0x11 then 0x22 with no rx_read -> rx_data=0x22 and rx_overrun=1; rx_read -> rx_valid=0 and rx_overrun=0.
REQ-034 SHALL cover: rst_n=0 during T_SEND and R_CLEAR -> all outputs 0 next cycle, and req0 wins the first grant after reset.

Source files
------------

// File: rtl/uart_arbiter.sv
// Two-requester round-robin arbiter in front of a byte UART transmitter,
// plus a single-entry holding register with overrun detection for the receiver.
module uart_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       uart_start_tx,
    output logic [7:0] uart_tx_value,
    input  logic       uart_tx_done,
    input  logic       uart_rx_available,
    input  logic [7:0] uart_rx_value,
    output logic       uart_rx_clear,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_read,
    output logic       rx_overrun,
    output logic       tx_busy,
    output logic       tx_grant
);

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_SEND    = 2'd1,
        T_RELEASE = 2'd2
    } tx_state_t;

    typedef enum logic {
        R_WAIT  = 1'b0,
        R_CLEAR = 1'b1
    } rx_state_t;

    tx_state_t tx_state;
    rx_state_t rx_state;
    logic      prio;        // requester preferred on a tie; 0 after reset
    logic      any_valid;
    logic      winner;
    logic      grant_now;
    logic      capture;

    // Round-robin pick: a lone requester always wins, a tie goes to prio.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            winner = prio;
        end else if (req1_valid) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

    // Ready is combinational so the byte is taken on the same edge it is acknowledged.
    assign grant_now  = rst_n & (tx_state == T_IDLE) & any_valid;
    assign req0_ready = grant_now & ~winner;
    assign req1_ready = grant_now & winner;
    assign capture    = (rx_state == R_WAIT) & uart_rx_available;

    // Transmit FSM: grant, hold start until done, wait for done to drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state      <= T_IDLE;
            uart_start_tx <= 1'b0;
            uart_tx_value <= 8'h00;
            tx_busy       <= 1'b0;
            tx_grant      <= 1'b0;
            prio          <= 1'b0;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (any_valid) begin
                        uart_tx_value <= winner ? req1_data : req0_data;
                        tx_grant      <= winner;
                        prio          <= ~winner;
                        uart_start_tx <= 1'b1;
                        tx_busy       <= 1'b1;
                        tx_state      <= T_SEND;
                    end
                end
                T_SEND: begin
                    if (uart_tx_done) begin
                        uart_start_tx <= 1'b0;
                        tx_state      <= T_RELEASE;
                    end
                end
                T_RELEASE: begin
                    if (!uart_tx_done) begin
                        tx_busy  <= 1'b0;
                        tx_state <= T_IDLE;
                    end
                end
                default: begin
                    uart_start_tx <= 1'b0;
                    tx_busy       <= 1'b0;
                    tx_state      <= T_IDLE;
                end
            endcase
        end
    end

    // Receive FSM: one capture per byte, clear held until the UART drops available.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state      <= R_WAIT;
            uart_rx_clear <= 1'b0;
        end else begin
            case (rx_state)
                R_WAIT: begin
                    if (uart_rx_available) begin
                        uart_rx_clear <= 1'b1;
                        rx_state      <= R_CLEAR;
                    end
                end
                R_CLEAR: begin
                    if (!uart_rx_available) begin
                        uart_rx_clear <= 1'b0;
                        rx_state      <= R_WAIT;
                    end
                end
                default: begin
                    uart_rx_clear <= 1'b0;
                    rx_state      <= R_WAIT;
                end
            endcase
        end
    end

    // Holding register: a capture wins over a pop; overrun only when unread data is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid   <= 1'b0;
            rx_data    <= 8'h00;
            rx_overrun <= 1'b0;
        end else if (capture) begin
            rx_data  <= uart_rx_value;
            rx_valid <= 1'b1;
            if (rx_valid && !rx_read) begin
                rx_overrun <= 1'b1;
            end
        end else if (rx_read && rx_valid) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_arbiter.sv
// Bench for uart_arbiter: per-cycle vector table, reset-mid-transfer sequence,
// and a scoreboard checking round-robin order seen by the UART.
module tb_uart_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       uart_start_tx;
    logic [7:0] uart_tx_value;
    logic       uart_tx_done;
    logic       uart_rx_available;
    logic [7:0] uart_rx_value;
    logic       uart_rx_clear;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_read;
    logic       rx_overrun;
    logic       tx_busy;
    logic       tx_grant;

    int tests = 0;
    int fails = 0;

    uart_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req0_valid        (req0_valid),
        .req0_data         (req0_data),
        .req0_ready        (req0_ready),
        .req1_valid        (req1_valid),
        .req1_data         (req1_data),
        .req1_ready        (req1_ready),
        .uart_start_tx     (uart_start_tx),
        .uart_tx_value     (uart_tx_value),
        .uart_tx_done      (uart_tx_done),
        .uart_rx_available (uart_rx_available),
        .uart_rx_value     (uart_rx_value),
        .uart_rx_clear     (uart_rx_clear),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .rx_read           (rx_read),
        .rx_overrun        (rx_overrun),
        .tx_busy           (tx_busy),
        .tx_grant          (tx_grant)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       dn;
        logic       av;
        logic [7:0] rv;
        logic       rd;
    } in_t;

    typedef struct packed {
        logic       r0;
        logic       r1;
        logic       st;
        logic [7:0] tv;
        logic       cl;
        logic       rxv;
        logic [7:0] rxd;
        logic       ov;
        logic       busy;
        logic       gr;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t       vecs [24];
    logic [8:0] sbq [$];

    function automatic vec_t mk(input logic rst, input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1, input logic dn,
                                input logic av, input logic [7:0] rv, input logic rd,
                                input logic e0, input logic e1, input logic est,
                                input logic [7:0] etv, input logic ecl, input logic erxv,
                                input logic [7:0] erxd, input logic eov, input logic ebusy,
                                input logic egr);
        vec_t v;
        v.i = '{rst, v0, d0, v1, d1, dn, av, rv, rd};
        v.o = '{e0, e1, est, etv, ecl, erxv, erxd, eov, ebusy, egr};
        return v;
    endfunction

    function automatic out_t sample_out();
        out_t o;
        o = '{req0_ready, req1_ready, uart_start_tx, uart_tx_value, uart_rx_clear,
              rx_valid, rx_data, rx_overrun, tx_busy, tx_grant};
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for uart_start_tx to reach lvl; a timeout counts as a failure.
    task automatic wait_start(input logic lvl, input string name);
        int n;
        n = 0;
        while (uart_start_tx !== lvl && n < 50) begin
            step();
            n++;
        end
        check(name, {31'd0, uart_start_tx}, {31'd0, lvl});
    endtask

    initial begin
        logic       mprio;
        logic       w;
        logic [8:0] got;

        rst_n = 1'b0; req0_valid = 1'b0; req0_data = 8'h00; req1_valid = 1'b0;
        req1_data = 8'h00; uart_tx_done = 1'b0; uart_rx_available = 1'b0;
        uart_rx_value = 8'h00; rx_read = 1'b0;

        //                rst v0 d0     v1 d1     dn av rv     rd | r0 r1 st tv     cl rxv rxd    ov bs gr
        vecs[0]  = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0);
        vecs[1]  = mk(1'b1,1'b1,8'h55,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0);
        vecs[2]  = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b1,8'h55,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0);
        vecs[3]  = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b1,8'h55,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0);
        vecs[4]  = mk(1'b1,1'b1,8'hEE,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0);
        vecs[5]  = mk(1'b1,1'b1,8'hEE,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0);
        vecs[6]  = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0);
        vecs[7]  = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,8'h3C,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0);
        vecs[8]  = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,8'h3C,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b1,1'b1,8'h3C,1'b0,1'b0,1'b0);
        vecs[9]  = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b1,1'b1,8'h3C,1'b0,1'b0,1'b0);
        vecs[10] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b1,8'h3C,1'b0,1'b0,1'b0);
        vecs[11] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b1,8'h3C,1'b0,1'b0,1'b0);
        vecs[12] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,8'h11,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b0,8'h3C,1'b0,1'b0,1'b0);
        vecs[13] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b1,1'b1,8'h11,1'b0,1'b0,1'b0);
        vecs[14] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,8'h22,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b1,8'h11,1'b0,1'b0,1'b0);
        vecs[15] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b1,1'b1,8'h22,1'b1,1'b0,1'b0);
        vecs[16] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b1,8'h22,1'b1,1'b0,1'b0);
        vecs[17] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b0,8'h22,1'b0,1'b0,1'b0);
        vecs[18] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,8'h44,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b0,8'h22,1'b0,1'b0,1'b0);
        vecs[19] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b1,1'b1,8'h44,1'b0,1'b0,1'b0);
        vecs[20] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,8'h66,1'b1, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b1,8'h44,1'b0,1'b0,1'b0);
        vecs[21] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,1'b0,8'h55,1'b1,1'b1,8'h66,1'b0,1'b0,1'b0);
        vecs[22] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b1,8'h66,1'b0,1'b0,1'b0);
        vecs[23] = mk(1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,1'b0,8'h55,1'b0,1'b0,8'h66,1'b0,1'b0,1'b0);

        repeat (3) step();

        // Each row: drive inputs, check outputs within the same cycle, then clock.
        for (int k = 0; k < 24; k++) begin
            rst_n = vecs[k].i.rst;   req0_valid = vecs[k].i.v0; req0_data = vecs[k].i.d0;
            req1_valid = vecs[k].i.v1; req1_data = vecs[k].i.d1; uart_tx_done = vecs[k].i.dn;
            uart_rx_available = vecs[k].i.av; uart_rx_value = vecs[k].i.rv; rx_read = vecs[k].i.rd;
            #1;
            check($sformatf("vec%0d", k), {8'd0, sample_out()}, {8'd0, vecs[k].o});
            step();
        end

        // Lone req0 wins even though the tie preference now points at req1.
        rx_read = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h5A; uart_rx_available = 1'b1; uart_rx_value = 8'h99;
        #1;
        check("lone_req0_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
        step();
        req0_valid = 1'b0;
        check("mid_send_start", {31'd0, uart_start_tx}, 32'd1);
        check("mid_send_value", {24'd0, uart_tx_value}, 32'h5A);
        check("mid_rx_clear", {31'd0, uart_rx_clear}, 32'd1);

        // Reset while TX is sending and RX is clearing.
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("ready_in_reset", {30'd0, req0_ready, req1_ready}, 32'd0);
        step();
        check("reset_outputs", {8'd0, sample_out()}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0; uart_rx_available = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_idle", {8'd0, sample_out()}, 32'd0);

        // Scoreboard: model the tie-break from reset and push expected {grant, byte}.
        mprio = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w = mprio;
            sbq.push_back({w, w ? 8'hB2 : 8'hA1});
            mprio = ~w;
        end
        req0_valid = 1'b1; req0_data = 8'hA1; req1_valid = 1'b1; req1_data = 8'hB2;
        #1;
        check("first_grant_req0", {30'd0, req0_ready, req1_ready}, 32'd2);
        for (int k = 0; k < 4; k++) begin
            wait_start(1'b1, $sformatf("start_rise%0d", k));
            got = {tx_grant, uart_tx_value};
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_pop%0d: got %h, want nothing queued", k, got);
            end else begin
                check($sformatf("sb_pop%0d", k), {23'd0, got}, {23'd0, sbq.pop_front()});
            end
            if (k == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            step();
            step();
            check($sformatf("hold_value%0d", k), {23'd0, got}, {23'd0, tx_grant, uart_tx_value});
            uart_tx_done = 1'b1;
            wait_start(1'b0, $sformatf("start_fall%0d", k));
            uart_tx_done = 1'b0;
            step();
        end
        step();
        check("sb_drained", sbq.size(), 32'd0);
        check("final_idle", {29'd0, tx_busy, req0_ready, req1_ready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
